// File: rtl/byte_ram.sv
// Byte-addressable little-endian data memory for the RV32I datapath.
// Combinational zero-extended reads; byte/half/word writes on the rising clock edge.
module byte_ram #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        mem_sz,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_NONE = 2'b11
  } size_t;

  logic [7:0]       mem [DEPTH_BYTES];
  logic [IDX_W-1:0] idx0, idx1, idx2, idx3;
  size_t            size;
  logic             unused_addr;

  // Index arithmetic is IDX_W bits wide, so the top of memory wraps to 0 for free.
  assign idx0        = addr[IDX_W-1:0];
  assign idx1        = idx0 + IDX_W'(1);
  assign idx2        = idx0 + IDX_W'(2);
  assign idx3        = idx0 + IDX_W'(3);
  assign size        = size_t'(mem_sz);
  assign unused_addr = ^addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      case (size)
        SZ_BYTE: begin
          mem[idx0] <= data_i[7:0];
        end
        SZ_HALF: begin
          mem[idx0] <= data_i[7:0];
          mem[idx1] <= data_i[15:8];
        end
        SZ_WORD: begin
          mem[idx0] <= data_i[7:0];
          mem[idx1] <= data_i[15:8];
          mem[idx2] <= data_i[23:16];
          mem[idx3] <= data_i[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_o = 32'h0;
    case (size)
      SZ_BYTE: data_o = {24'h0, mem[idx0]};
      SZ_HALF: data_o = {16'h0, mem[idx1], mem[idx0]};
      SZ_WORD: data_o = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
      default: data_o = 32'h0;
    endcase
  end

  // An unknown write enable would silently corrupt or skip a store.
  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(wr_en));

endmodule

// File: tb/tb_byte_ram.sv
// Directed self-checking bench for byte_ram with hand-computed expected values.
module tb_byte_ram;

  localparam int DEPTH = 1024;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        wr_en  = 1'b0;
  logic [1:0]  mem_sz = 2'b11;
  logic [31:0] addr   = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;

  int vectors     = 0;
  int miscompares = 0;

  byte_ram #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .mem_sz (mem_sz),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
    wr_en  = we;
    mem_sz = sz;
    addr   = a;
    data_i = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    applyStimulus(1'b1, sz, a, d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] exp);
    applyStimulus(1'b0, sz, a, 32'h0);
    #1;
    checkOutput(tag, data_o, exp);
  endtask

  initial begin
    // Reset, then scan words.
    rst_n = 1'b0;
    #12;
    read_check("rst_word", 2'b10, 32'h10, 32'h0);
    read_check("rst_half", 2'b01, 32'h11, 32'h0);
    read_check("rst_byte", 2'b00, 32'h3FF, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 4; a <= 252; a += 4) begin
      read_check("scan_zero", 2'b10, 32'(a), 32'h0);
    end

    // Word write and sub-word reads.
    do_write(2'b10, 32'h10, 32'hDEADBEEF);
    read_check("w_word10", 2'b10, 32'h10, 32'hDEADBEEF);
    read_check("w_byte10", 2'b00, 32'h10, 32'h000000EF);
    read_check("w_byte13", 2'b00, 32'h13, 32'h000000DE);
    read_check("w_half12", 2'b01, 32'h12, 32'h0000DEAD);
    read_check("w_half11", 2'b01, 32'h11, 32'h0000ADBE);
    read_check("w_none10", 2'b11, 32'h10, 32'h0);

    // Partial writes leave neighbours untouched.
    do_write(2'b00, 32'h11, 32'hFFFFFF55);
    read_check("pb_word10", 2'b10, 32'h10, 32'hDEAD55EF);
    do_write(2'b01, 32'h12, 32'hFFFF1234);
    read_check("ph_word10", 2'b10, 32'h10, 32'h123455EF);
    read_check("ph_byte14", 2'b00, 32'h14, 32'h0);

    // Misaligned access wrapping across the top of memory.
    do_write(2'b10, 32'(DEPTH - 2), 32'hA1B2C3D4);
    read_check("wrap_b_m2", 2'b00, 32'(DEPTH - 2), 32'h000000D4);
    read_check("wrap_b_m1", 2'b00, 32'(DEPTH - 1), 32'h000000C3);
    read_check("wrap_b_0",  2'b00, 32'h0, 32'h000000B2);
    read_check("wrap_b_1",  2'b00, 32'h1, 32'h000000A1);
    read_check("wrap_word", 2'b10, 32'(DEPTH - 2), 32'hA1B2C3D4);
    read_check("wrap_half", 2'b01, 32'(DEPTH - 1), 32'h0000B2C3);
    read_check("wrap_b_m3", 2'b00, 32'(DEPTH - 3), 32'h0);

    // Upper address bits alias; size 11 never writes and reads zero.
    do_write(2'b10, 32'(DEPTH + 8), 32'h11111111);
    read_check("alias_8", 2'b10, 32'h8, 32'h11111111);
    read_check("alias_hi", 2'b10, 32'h8000_0008, 32'h11111111);
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 32'h8, 32'hFFFFFFFF);
    #1;
    checkOutput("none_out", data_o, 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    read_check("none_keep", 2'b10, 32'h8, 32'h11111111);

    // Read during write shows old data until the edge, new data right after.
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 32'h20, 32'h0BADF00D);
    #1;
    checkOutput("rdw_before", data_o, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rdw_after", data_o, 32'h0BADF00D);
    wr_en = 1'b0;

    // Asynchronous reset between edges clears memory; writes blocked meanwhile.
    read_check("pre_rst", 2'b10, 32'h10, 32'h123455EF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", data_o, 32'h0);
    applyStimulus(1'b1, 2'b10, 32'h10, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checkOutput("rst_blk_wr", data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("post_rst10", 2'b10, 32'h10, 32'h0);
    read_check("post_rst8",  2'b10, 32'h8, 32'h0);
    read_check("post_rstwr", 2'b10, 32'(DEPTH - 2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
